// File: rtl/dff_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dff_rr_arbiter
//
// Round-robin arbiter in front of one shared output register. Each cycle it
// picks one requester, starting the search at a rotating pointer, and loads
// that requester's word into the output register. The word is held with
// DataValid until the consumer takes it with DataReady. A consume and a new
// load can happen on the same edge, so a full register does not cause a bubble.
//
// Ports
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   Req        in   [N]        per-requester request, held until granted
//   DataIn     in   [N*WIDTH]  word of requester i at [i*WIDTH +: WIDTH]
//   Grant      out  [N]        one-hot; requester i is taken at this edge
//   DataOut    out  [WIDTH]    registered shared data word
//   DataValid  out             DataOut holds an unconsumed word
//   SrcId      out  [IDW]      requester that produced DataOut
//   DataReady  in              consumer takes DataOut this cycle
// -----------------------------------------------------------------------------
module dff_rr_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(N)
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [N-1:0]         Req,
   input  logic [N*WIDTH-1:0]   DataIn,
   output logic [N-1:0]         Grant,
   output logic [WIDTH-1:0]     DataOut,
   output logic                 DataValid,
   output logic [IDW-1:0]       SrcId,
   input  logic                 DataReady
);

   // EMPTY/FULL describes the output register.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t               state_reg, state_next;
   logic [IDW-1:0]       ptr_reg, ptr_next;
   logic [IDW-1:0]       src_reg;
   logic [WIDTH-1:0]     data_reg;
   logic [IDW-1:0]       winner;
   logic                 found;
   logic                 accept;
   logic [IDW:0]         cand_sum;
   logic [IDW-1:0]       cand;
   logic [WIDTH-1:0]     word [N];

   // Split the flat input bus into words and build the one-hot grant.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign word[gi]  = DataIn[gi*WIDTH +: WIDTH];
      assign Grant[gi] = accept && (winner == IDW'(gi));
   end

   // Cyclic priority search: Ptr, Ptr+1, ..., N-1, 0, ..., Ptr-1.
   // The candidate index is formed one bit wider so the modulo-N wrap
   // works for any N, including non-powers of two.
   always_comb begin
      winner   = '0;
      found    = 1'b0;
      cand_sum = '0;
      cand     = '0;
      for (int k = 0; k < N; k++) begin
         cand_sum = {1'b0, ptr_reg} + (IDW+1)'(k);
         if (cand_sum >= (IDW+1)'(N)) begin
            cand_sum = cand_sum - (IDW+1)'(N);
         end
         cand = cand_sum[IDW-1:0];
         if (!found && Req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // A new word may be taken when the register is empty or is being
   // consumed this cycle. Reset blocks grants while it is asserted.
   assign accept = found && !Reset &&
                   ((state_reg == ST_EMPTY) || DataReady);

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         ST_EMPTY: begin
            if (accept) begin
               state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            if (accept) begin
               state_next = ST_FULL;
            end else if (DataReady) begin
               state_next = ST_EMPTY;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
      if (accept) begin
         // Explicit wrap keeps the pointer inside 0..N-1 for any N.
         ptr_next = (winner == IDW'(N-1)) ? '0 : winner + IDW'(1);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_reg <= ST_EMPTY;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
      end
   end

   // Shared data stage: loads only on accept, otherwise holds its word
   // (also after the consumer drains it).
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         data_reg <= '0;
         src_reg  <= '0;
      end else if (accept) begin
         data_reg <= word[winner];
         src_reg  <= winner;
      end
   end

   assign DataOut   = data_reg;
   assign SrcId     = src_reg;
   assign DataValid = (state_reg == ST_FULL);

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_rr_arbiter
//
// Directed bench for dff_rr_arbiter. A reference model in the bench predicts
// the grant for each cycle. Granted words are queued and then compared when
// they appear on DataOut. A second instance with N=3 covers the
// non-power-of-two wrap.
// -----------------------------------------------------------------------------
module tb_dff_rr_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [N*W-1:0]   din;
   logic             ready;
   logic [N-1:0]     grant;
   logic [W-1:0]     dout;
   logic             dvalid;
   logic [IDW-1:0]   src;

   logic [2:0]       req3;
   logic [3*W-1:0]   din3;
   logic             ready3;
   logic [2:0]       grant3;
   logic [W-1:0]     dout3;
   logic             dvalid3;
   logic [1:0]       src3;

   always #5 clk = ~clk;

   dff_rr_arbiter #(.N(N), .WIDTH(W), .IDW(IDW)) dut (
      .Clock     (clk),
      .Reset     (rst),
      .Req       (req),
      .DataIn    (din),
      .Grant     (grant),
      .DataOut   (dout),
      .DataValid (dvalid),
      .SrcId     (src),
      .DataReady (ready)
   );

   dff_rr_arbiter #(.N(3), .WIDTH(W), .IDW(2)) dut3 (
      .Clock     (clk),
      .Reset     (rst),
      .Req       (req3),
      .DataIn    (din3),
      .Grant     (grant3),
      .DataOut   (dout3),
      .DataValid (dvalid3),
      .SrcId     (src3),
      .DataReady (ready3)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [W-1:0]   d;
      logic [IDW-1:0] s;
   } item_t;

   item_t          exp_q[$];
   logic [IDW-1:0] m_ptr;
   logic           m_valid;
   logic [W-1:0]   m_data;
   logic [IDW-1:0] m_src;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
      $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_ptr   = '0;
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = '0;
      exp_q.delete();
   endtask

   // One clock cycle with the inputs currently driven. The model predicts
   // the grant, the granted word is queued, and it is popped and compared
   // once the DUT shows it after the edge.
   task automatic step(input string tag, output logic [N-1:0] g_obs);
      int             w;
      int             idx;
      bit             acc;
      logic [N-1:0]   eg;
      item_t          it;
      w = -1;
      for (int k = 0; k < N; k++) begin
         idx = (int'(m_ptr) + k) % N;
         if (w < 0 && req[idx]) w = idx;
      end
      acc = (w >= 0) && (!m_valid || ready);
      eg  = '0;
      if (acc) eg[w] = 1'b1;
      #1;
      g_obs = grant;
      check({tag, ".grant"}, 32'(grant), 32'(eg));
      if (acc) begin
         it.d = din[w*W +: W];
         it.s = IDW'(w);
         exp_q.push_back(it);
      end
      @(posedge clk);
      #1;
      if (acc) begin
         it      = exp_q.pop_front();
         m_valid = 1'b1;
         m_data  = it.d;
         m_src   = it.s;
         m_ptr   = IDW'((w + 1) % N);
      end else if (m_valid && ready) begin
         m_valid = 1'b0;
      end
      check({tag, ".valid"}, 32'(dvalid), 32'(m_valid));
      check({tag, ".data"},  32'(dout),   32'(m_data));
      check({tag, ".src"},   32'(src),    32'(m_src));
      check({tag, ".ptr"},   32'(dut.ptr_reg), 32'(m_ptr));
   endtask

   initial begin
      logic [N-1:0] g;
      logic [N-1:0] exp_g [5];
      logic [W-1:0] exp_w;
      logic [2:0]   exp_g3;

      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

      // Reset: grant must stay low even with requests pending.
      rst    = 1'b1;
      req    = 4'b1111;
      din    = '0;
      ready  = 1'b0;
      req3   = '0;
      din3   = '0;
      ready3 = 1'b0;
      model_reset();
      #2;
      check("rst.grant", 32'(grant), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst.valid", 32'(dvalid), 32'h0);
      check("rst.data",  32'(dout),   32'h0);
      check("rst.src",   32'(src),    32'h0);
      check("rst.ptr",   32'(dut.ptr_reg), 32'h0);
      rst = 1'b0;
      req = '0;

      // Full contention: 0001,0010,0100,1000,0001 with words A0..A3,A0.
      din   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      req   = 4'b1111;
      ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step("full", g);
         check("full.grant_seq", 32'(g), 32'(exp_g[i]));
         exp_w = 8'hA0 + 8'(i % 4);
         check("full.data_seq", 32'(dout), 32'(exp_w));
         check("full.valid_seq", 32'(dvalid), 32'h1);
      end

      // Backpressure: load 0x5C from requester 2, stall 3 cycles.
      req = 4'b0100;
      din = {8'hA3, 8'h5C, 8'hA1, 8'hA0};
      step("bp_load", g);
      check("bp_load.grant", 32'(g), 32'h4);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("bp_stall", g);
         check("bp_stall.grant", 32'(g), 32'h0);
         check("bp_stall.data",  32'(dout), 32'h5C);
         check("bp_stall.src",   32'(src),  32'h2);
      end
      ready = 1'b1;
      din   = {8'hA3, 8'h5D, 8'hA1, 8'hA0};
      step("bp_release", g);
      check("bp_release.grant", 32'(g), 32'h4);
      check("bp_release.data",  32'(dout), 32'h5D);

      // Pointer at 3, Req=0011: wrap to requester 0, then requester 1.
      check("wrap.ptr_before", 32'(dut.ptr_reg), 32'h3);
      req = 4'b0011;
      step("wrap0", g);
      check("wrap0.grant", 32'(g), 32'h1);
      check("wrap0.ptr",   32'(dut.ptr_reg), 32'h1);
      step("wrap1", g);
      check("wrap1.grant", 32'(g), 32'h2);

      // Drain: valid falls after one edge, data held.
      req = '0;
      step("drain", g);
      check("drain.valid", 32'(dvalid), 32'h0);
      check("drain.data",  32'(dout),   32'hA1);
      step("drain_idle", g);

      // Reset mid-operation with DataValid=1 and Ptr=2.
      req = 4'b0010;
      step("pre_rst", g);
      check("pre_rst.ptr", 32'(dut.ptr_reg), 32'h2);
      req   = 4'b1111;
      ready = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check("midrst.valid", 32'(dvalid), 32'h0);
      check("midrst.data",  32'(dout),   32'h0);
      check("midrst.src",   32'(src),    32'h0);
      check("midrst.grant", 32'(grant),  32'h0);
      check("midrst.ptr",   32'(dut.ptr_reg), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      ready = 1'b1;
      step("post_rst", g);
      check("post_rst.grant", 32'(g), 32'h1);

      // N=3 instance: grants 001,010,100 repeating, pointer stays below 3.
      req  = '0;
      din3 = {8'hC2, 8'hC1, 8'hC0};
      ready3 = 1'b1;
      req3   = 3'b111;
      for (int i = 0; i < 6; i++) begin
         #1;
         exp_g3 = 3'b001 << (i % 3);
         check("n3.grant", 32'(grant3), 32'(exp_g3));
         @(posedge clk);
         #1;
         exp_w = 8'hC0 + 8'(i % 3);
         check("n3.data",  32'(dout3),  32'(exp_w));
         check("n3.src",   32'(src3),   32'(i % 3));
         check("n3.valid", 32'(dvalid3), 32'h1);
         check("n3.ptr",   32'(dut3.ptr_reg), 32'((i + 1) % 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety net against a hang.
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
